// File: rtl/mem_stage.sv
// MIPS MEM stage: decodes loads/stores, accesses a word-organised data memory, flags address errors, latches MEM/WB.
// Latency: one cycle from in_* to the registered outputs; stores commit on the same edge, so a following load sees them.
// No backpressure: one instruction is accepted every cycle; flush turns the latched result into a bubble.
module mem_stage #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] in_IR,
  input  logic [4:0]  in_A3,
  input  logic [31:0] in_V2,
  input  logic [31:0] in_AO,
  input  logic [31:0] in_PCp4,
  input  logic        in_RegWrite,
  input  logic        in_MemtoReg,
  input  logic        in_MemWrite,
  input  logic        in_Link,
  input  logic        in_CP0WE,
  input  logic [4:0]  in_X,
  input  logic        in_AWAY,
  output logic [31:0] IR,
  output logic [4:0]  A3,
  output logic [31:0] AO,
  output logic [31:0] PCp4,
  output logic [31:0] DR,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        Link,
  output logic        CP0WE,
  output logic [4:0]  X,
  output logic        AWAY
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int BW = AW + 2;

  localparam logic [5:0] OP_LW = 6'h23, OP_LH = 6'h21, OP_LHU = 6'h25, OP_LB = 6'h20, OP_LBU = 6'h24;
  localparam logic [5:0] OP_SW = 6'h2B, OP_SH = 6'h29, OP_SB = 6'h28;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          is_load, is_store, sz_word, sz_half, sz_byte, sext;
  logic          addr_err;
  logic [4:0]    code;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [15:0]   rd_half;
  logic [7:0]    rd_byte;
  logic [31:0]   load_data;
  logic [31:0]   mem_wdata_d;
  logic          st_en;

  logic [31:0] ir_d, ao_d, pcp4_d, dr_d, ir_q, ao_q, pcp4_q, dr_q;
  logic [4:0]  a3_d, x_d, a3_q, x_q;
  logic        regwrite_d, memtoreg_d, link_d, cp0we_d, away_d;
  logic        regwrite_q, memtoreg_q, link_q, cp0we_q, away_q;

  // Opcode decode, address-error detection and resulting exception code.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sz_word  = 1'b0;
    sz_half  = 1'b0;
    sz_byte  = 1'b0;
    sext     = 1'b0;
    unique case (in_IR[31:26])
      OP_LW:   begin is_load = 1'b1;  sz_word = 1'b1; end
      OP_LH:   begin is_load = 1'b1;  sz_half = 1'b1; sext = 1'b1; end
      OP_LHU:  begin is_load = 1'b1;  sz_half = 1'b1; end
      OP_LB:   begin is_load = 1'b1;  sz_byte = 1'b1; sext = 1'b1; end
      OP_LBU:  begin is_load = 1'b1;  sz_byte = 1'b1; end
      OP_SW:   begin is_store = 1'b1; sz_word = 1'b1; end
      OP_SH:   begin is_store = 1'b1; sz_half = 1'b1; end
      OP_SB:   begin is_store = 1'b1; sz_byte = 1'b1; end
      default: ;
    endcase
    addr_err = (is_load | is_store) &
               ((|in_AO[31:BW]) | (sz_word & (|in_AO[1:0])) | (sz_half & in_AO[0]));
    // An exception from an earlier stage always wins over our own address error.
    if (in_X != 5'd0)  code = in_X;
    else if (addr_err) code = is_load ? 5'd4 : 5'd5;
    else               code = 5'd0;
  end

  // Combinational read of the addressed word, lane extraction and store-data merge.
  always_comb begin
    word_idx  = in_AO[BW-1:2];
    rd_word   = mem_q[word_idx];
    rd_half   = in_AO[1] ? rd_word[31:16] : rd_word[15:0];
    rd_byte   = rd_word[{in_AO[1:0], 3'b000} +: 8];
    load_data = 32'd0;
    if (sz_word)      load_data = rd_word;
    else if (sz_half) load_data = {{16{sext & rd_half[15]}}, rd_half};
    else if (sz_byte) load_data = {{24{sext & rd_byte[7]}}, rd_byte};
    // Start from the current word so unwritten lanes are preserved.
    mem_wdata_d = rd_word;
    if (sz_word)      mem_wdata_d = in_V2;
    else if (sz_half) mem_wdata_d[{in_AO[1], 4'b0000} +: 16] = in_V2[15:0];
    else if (sz_byte) mem_wdata_d[{in_AO[1:0], 3'b000} +: 8] = in_V2[7:0];
    st_en = is_store & in_MemWrite & (code == 5'd0) & ~flush & ~reset;
  end

  // MEM/WB next values: bubble on flush, kill writes when an exception is raised.
  always_comb begin
    ir_d       = in_IR;
    a3_d       = in_A3;
    ao_d       = in_AO;
    pcp4_d     = in_PCp4;
    dr_d       = is_load ? load_data : 32'd0;
    regwrite_d = (code == 5'd0) & in_RegWrite;
    memtoreg_d = (code == 5'd0) & in_MemtoReg;
    cp0we_d    = (code == 5'd0) & in_CP0WE;
    link_d     = in_Link;
    away_d     = in_AWAY;
    x_d        = code;
    if (flush) begin
      ir_d       = 32'd0;
      a3_d       = 5'd0;
      ao_d       = 32'd0;
      pcp4_d     = 32'd0;
      dr_d       = 32'd0;
      regwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      cp0we_d    = 1'b0;
      link_d     = 1'b0;
      away_d     = 1'b0;
      x_d        = 5'd0;
    end
  end

  // Data memory: whole array cleared by reset, one word written per store.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'd0;
    end else if (st_en) begin
      mem_q[word_idx] <= mem_wdata_d;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      ir_q <= '0; a3_q <= '0; ao_q <= '0; pcp4_q <= '0; dr_q <= '0; x_q <= '0;
      regwrite_q <= 1'b0; memtoreg_q <= 1'b0; link_q <= 1'b0; cp0we_q <= 1'b0; away_q <= 1'b0;
    end else begin
      ir_q <= ir_d; a3_q <= a3_d; ao_q <= ao_d; pcp4_q <= pcp4_d; dr_q <= dr_d; x_q <= x_d;
      regwrite_q <= regwrite_d; memtoreg_q <= memtoreg_d; link_q <= link_d;
      cp0we_q <= cp0we_d; away_q <= away_d;
    end
  end

  assign IR       = ir_q;
  assign A3       = a3_q;
  assign AO       = ao_q;
  assign PCp4     = pcp4_q;
  assign DR       = dr_q;
  assign RegWrite = regwrite_q;
  assign MemtoReg = memtoreg_q;
  assign Link     = link_q;
  assign CP0WE    = cp0we_q;
  assign X        = x_q;
  assign AWAY     = away_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed sequence followed by randomized instructions.
// Expected MEM/WB contents come from a byte-array reference model and are queued per instruction.
// A negedge monitor pops the entry due that cycle and compares every registered output.
module tb_mem_stage;

  localparam int MEM_BYTES = 4096;

  logic        CLK = 1'b0;
  logic        reset, flush;
  logic [31:0] in_IR, in_V2, in_AO, in_PCp4;
  logic [4:0]  in_A3, in_X;
  logic        in_RegWrite, in_MemtoReg, in_MemWrite, in_Link, in_CP0WE, in_AWAY;
  logic [31:0] IR, AO, PCp4, DR;
  logic [4:0]  A3, X;
  logic        RegWrite, MemtoReg, Link, CP0WE, AWAY;

  mem_stage #(.DEPTH_WORDS(1024)) dut (
    .CLK(CLK), .reset(reset), .flush(flush),
    .in_IR(in_IR), .in_A3(in_A3), .in_V2(in_V2), .in_AO(in_AO), .in_PCp4(in_PCp4),
    .in_RegWrite(in_RegWrite), .in_MemtoReg(in_MemtoReg), .in_MemWrite(in_MemWrite),
    .in_Link(in_Link), .in_CP0WE(in_CP0WE), .in_X(in_X), .in_AWAY(in_AWAY),
    .IR(IR), .A3(A3), .AO(AO), .PCp4(PCp4), .DR(DR),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .Link(Link), .CP0WE(CP0WE), .X(X), .AWAY(AWAY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] ir, ao, pcp4, dr;
    logic [4:0]  a3, x;
    logic        regwrite, memtoreg, link, cp0we, away;
  } out_t;

  out_t        exp_q [$];
  int          due_q [$];
  string       name_q [$];
  int          cycle = 0;
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  mbytes [MEM_BYTES];

  always @(posedge CLK) cycle <= cycle + 1;

  // Monitor: compare the outputs latched for the instruction due in this cycle.
  always @(negedge CLK) begin
    out_t  e, a;
    string n;
    if (due_q.size() > 0 && due_q[0] == cycle) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      void'(due_q.pop_front());
      a.ir = IR; a.ao = AO; a.pcp4 = PCp4; a.dr = DR; a.a3 = A3; a.x = X;
      a.regwrite = RegWrite; a.memtoreg = MemtoReg; a.link = Link; a.cp0we = CP0WE; a.away = AWAY;
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s cyc=%0d got IR=%h AO=%h PCp4=%h DR=%h A3=%0d X=%0d RW=%b MR=%b L=%b CW=%b AW=%b want IR=%h AO=%h PCp4=%h DR=%h A3=%0d X=%0d RW=%b MR=%b L=%b CW=%b AW=%b",
                 n, cycle, a.ir, a.ao, a.pcp4, a.dr, a.a3, a.x, a.regwrite, a.memtoreg, a.link, a.cp0we, a.away,
                 e.ir, e.ao, e.pcp4, e.dr, e.a3, e.x, e.regwrite, e.memtoreg, e.link, e.cp0we, e.away);
      end
    end
  end

  // Reference model: applies the instruction to the byte array and returns the expected MEM/WB contents.
  function automatic out_t model(input logic rst, input logic fl, input logic [31:0] ir,
                                 input logic [31:0] ao, input logic [31:0] v2, input logic [4:0] xin,
                                 input logic [4:0] a3, input logic [31:0] pcp4, input logic rw,
                                 input logic mtr, input logic mw, input logic lnk, input logic cw,
                                 input logic away);
    out_t        r;
    bit          ld, st, sgn, ae;
    int unsigned sz, off;
    longint      val;
    logic [4:0]  code;
    r = '0;
    ld = 0; st = 0; sgn = 0; sz = 4;
    case (ir[31:26])
      6'h23: begin ld = 1; sz = 4; end
      6'h21: begin ld = 1; sz = 2; sgn = 1; end
      6'h25: begin ld = 1; sz = 2; end
      6'h20: begin ld = 1; sz = 1; sgn = 1; end
      6'h24: begin ld = 1; sz = 1; end
      6'h2B: begin st = 1; sz = 4; end
      6'h29: begin st = 1; sz = 2; end
      6'h28: begin st = 1; sz = 1; end
      default: ;
    endcase
    if (rst) begin
      for (int i = 0; i < MEM_BYTES; i++) mbytes[i] = 8'h00;
      return r;
    end
    if (fl) return r;
    ae = (ld || st) && (ao >= MEM_BYTES || (ao % sz) != 0);
    code = (xin != 0) ? xin : (ae ? (ld ? 5'd4 : 5'd5) : 5'd0);
    if (ld) begin
      // Address bits above the memory span and below the access size are ignored for the read.
      off = (ao % MEM_BYTES) - ((ao % MEM_BYTES) % sz);
      val = 0;
      for (int k = 0; k < int'(sz); k++) val = val | (longint'(mbytes[off + k]) << (8 * k));
      if (sgn && val[8*sz-1]) val = val - (longint'(1) << (8 * sz));
      r.dr = val[31:0];
    end
    if (st && mw && code == 0)
      for (int k = 0; k < int'(sz); k++) mbytes[ao + k] = v2[8*k +: 8];
    r.ir = ir; r.ao = ao; r.pcp4 = pcp4; r.a3 = a3; r.x = code;
    r.regwrite = (code == 0) && rw;
    r.memtoreg = (code == 0) && mtr;
    r.cp0we    = (code == 0) && cw;
    r.link     = lnk;
    r.away     = away;
    return r;
  endfunction

  // Drive one instruction for one cycle and queue the outputs it must produce a cycle later.
  task automatic issue(input string nm, input logic rst, input logic fl, input logic [5:0] op,
                       input logic [31:0] ao, input logic [31:0] v2, input logic [4:0] xin,
                       input logic rw, input logic mw);
    logic [25:0] low;
    low = 26'($urandom);
    reset = rst; flush = fl;
    in_IR = {op, low}; in_AO = ao; in_V2 = v2; in_X = xin;
    in_A3 = 5'($urandom); in_PCp4 = $urandom;
    in_RegWrite = rw; in_MemWrite = mw;
    in_MemtoReg = 1'($urandom); in_Link = 1'($urandom);
    in_CP0WE = 1'($urandom); in_AWAY = 1'($urandom);
    exp_q.push_back(model(rst, fl, in_IR, ao, v2, xin, in_A3, in_PCp4, rw,
                          in_MemtoReg, mw, in_Link, in_CP0WE, in_AWAY));
    due_q.push_back(cycle + 1);
    name_q.push_back(nm);
    @(posedge CLK);
    #1;
  endtask

  logic [5:0] ops [10];

  initial begin
    ops = '{6'h23, 6'h21, 6'h25, 6'h20, 6'h24, 6'h2B, 6'h29, 6'h28, 6'h00, 6'h0F};
    #1;
    issue("reset",        1, 0, 6'h2B, 32'h10,   32'h1111_1111, 0, 1, 1);
    issue("sw_10",        0, 0, 6'h2B, 32'h10,   32'hDEADBEEF,  0, 1, 1);
    issue("lw_10",        0, 0, 6'h23, 32'h10,   32'h0,         0, 1, 0);
    issue("sb_11",        0, 0, 6'h28, 32'h11,   32'h0000_0080, 0, 0, 1);
    issue("lw_10_sb",     0, 0, 6'h23, 32'h10,   32'h0,         0, 1, 0);
    issue("lb_11",        0, 0, 6'h20, 32'h11,   32'h0,         0, 1, 0);
    issue("lbu_11",       0, 0, 6'h24, 32'h11,   32'h0,         0, 1, 0);
    issue("sh_12",        0, 0, 6'h29, 32'h12,   32'hAAAA_1234, 0, 0, 1);
    issue("lw_10_sh",     0, 0, 6'h23, 32'h10,   32'h0,         0, 1, 0);
    issue("lh_12",        0, 0, 6'h21, 32'h12,   32'h0,         0, 1, 0);
    issue("lw_13_adel",   0, 0, 6'h23, 32'h13,   32'h0,         0, 1, 0);
    issue("sw_20",        0, 0, 6'h2B, 32'h20,   32'hCAFEF00D,  0, 0, 1);
    issue("sh_21_ades",   0, 0, 6'h29, 32'h21,   32'h0000_5555, 0, 0, 1);
    issue("lw_20_after",  0, 0, 6'h23, 32'h20,   32'h0,         0, 1, 0);
    issue("sw_1000_ades", 0, 0, 6'h2B, 32'h1000, 32'h7777_7777, 0, 0, 1);
    issue("lw_0_after",   0, 0, 6'h23, 32'h0,    32'h0,         0, 1, 0);
    issue("sw_ffc",       0, 0, 6'h2B, 32'hFFC,  32'h0BAD_F00D, 0, 0, 1);
    issue("lw_ffc",       0, 0, 6'h23, 32'hFFC,  32'h0,         0, 1, 0);
    issue("lw_1000_adel", 0, 0, 6'h23, 32'h1000, 32'h0,         0, 1, 0);
    issue("x10_lw_13",    0, 0, 6'h23, 32'h13,   32'h0,         10, 1, 0);
    issue("flush_sw_40",  0, 1, 6'h2B, 32'h40,   32'h5,         0, 1, 1);
    issue("lw_40",        0, 0, 6'h23, 32'h40,   32'h0,         0, 1, 0);
    issue("reset_mid_sw", 1, 0, 6'h2B, 32'h10,   32'h9999_9999, 0, 1, 1);
    issue("lw_10_reset",  0, 0, 6'h23, 32'h10,   32'h0,         0, 1, 0);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] ao;
      logic [4:0]  xin;
      int          r;
      r = $urandom_range(0, 15);
      if (r == 0)      ao = $urandom;
      else if (r == 1) ao = 32'h1000 + $urandom_range(0, 7);
      else if (r == 2) ao = 32'hFFC + $urandom_range(0, 3);
      else             ao = $urandom_range(0, 127);
      xin = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
      issue("rand", $urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0,
            ops[$urandom_range(0, 9)], ao, $urandom, xin, 1'($urandom), $urandom_range(0, 7) != 0);
    end

    reset = 0; flush = 0; in_IR = 0; in_X = 0; in_MemWrite = 0;
    repeat (3) @(posedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expected results never compared, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

MEM-stage unit of the five-stage MIPS pipeline, consuming the fields latched by the EX/MEM pipeline register. It performs word, halfword and byte loads and stores against a 4 KiB data memory and detects address-error exceptions. It then latches the result and the forwarded control fields into the MEM/WB register that feeds the write-back stage.

## Interface
- DEPTH_WORDS, 1024: data-memory size in 32-bit words; byte address span is 4×DEPTH_WORDS.
- CLK  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- flush  in  1  exception/interrupt flush; when high, the current MEM instruction is killed.
- in_IR  in  32  instruction in MEM.
- in_A3  in  5  destination register.
- in_V2  in  32  store data, already forwarded.
- in_AO  in  32  ALU result / effective address.
- in_PCp4  in  32  PC+4 of the instruction.
- in_RegWrite, in_MemtoReg, in_MemWrite, in_Link, in_CP0WE  in  1 each  control fields from EX/MEM.
- in_X  in  5  exception code carried so far; 0 means none.
- in_AWAY  in  1  delay-slot/"away" flag carried along the pipeline.
- IR, AO, PCp4  out  32 each  registered copies for WB.
- A3  out  5  registered destination register.
- DR  out  32  registered, extended load data.
- RegWrite, MemtoReg, Link, CP0WE, AWAY  out  1 each  registered control fields.
- X  out  5  registered exception code.

## Operation
- Decode uses in_IR[31:26]:
  - Loads: lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24.
  - Stores: sw 0x2B, sh 0x29, sb 0x28.
  - Any other opcode is a non-memory operation.
- Memory word index is in_AO[11:2]; byte lane is in_AO[1:0]. Memory is little-endian: lane 0 holds bits [7:0].
- Address error for a load/store is raised when any of these holds:
  - in_AO[31:12] ≠ 0;
  - the access is word-sized and in_AO[1:0] ≠ 0;
  - the access is halfword-sized and in_AO[0] ≠ 0.
- Exception code:
  - If in_X ≠ 0, in_X is kept; earlier-stage exceptions take priority.
  - Else an address error gives 4 (AdEL) for a load, 5 (AdES) for a store.
  - Otherwise 0.
- Store enable = store opcode & in_MemWrite & resulting code == 0 & !flush & !reset.
  - sw writes all 4 lanes.
  - sh writes lanes {AO[1],0} and {AO[1],1} with in_V2[15:0].
  - sb writes lane AO[1:0] with in_V2[7:0].
  - Unwritten lanes are preserved.
- Load data is read combinationally from the addressed word.
  - lw: the full word.
  - lh/lhu: the halfword at AO[1], sign- or zero-extended.
  - lb/lbu: the byte at AO[1:0], sign- or zero-extended.
  - Non-loads: DR gets 0.
- Output latch, normal case: IR, A3, AO, PCp4, MemtoReg, Link, AWAY copy their inputs; X gets the resulting code.
- When the resulting code ≠ 0, RegWrite, CP0WE and MemtoReg are forced to 0.
- When flush is high, every output is latched to 0 (bubble) and no store occurs.

## Timing
- Reset: every output register is 0 on the first posedge with reset high. All DEPTH_WORDS memory words are cleared to 0 on that same edge.
- Latency: 1 cycle from in_* to the registered outputs.
- Store commits at the posedge ending the store's MEM cycle. A load in MEM on the next cycle reads the new value (store-to-load back-to-back correct, no stall).
- Load and store never occur in the same cycle (single instruction per stage).
- Priority when signals coincide: reset > flush > exception > normal.
- Reset asserted mid-sequence discards the instruction in MEM; no partial store.
- Address 0x00000FFC (highest word) is legal. 0x00001000 raises AdEL/AdES.

## Test plan
- Word store then load: sw V2=0xDEADBEEF AO=0x10, then lw AO=0x10 → next cycle DR=0xDEADBEEF, X=0, RegWrite=1.
- Sub-word store and extension, starting from word 0xDEADBEEF at 0x10:
  - sb V2=0x80 AO=0x11 → word = 0xDEAD80EF.
  - lb AO=0x11 → DR=0xFFFFFF80; lbu → DR=0x00000080.
  - sh V2=0x1234 AO=0x12 → word = 0x123480EF; lh AO=0x12 → DR=0x00001234.
- Misalignment:
  - lw AO=0x13 → X=4, RegWrite=0.
  - sh AO=0x21 → X=5, and a following lw AO=0x20 returns the prior contents unchanged.
- Range: sw AO=0x00001000 → X=5, no store. lw AO=0x00000FFC → X=0.
- Priority:
  - in_X=10 with misaligned lw → X=10.
  - flush=1 with sw AO=0x40 V2=5 → all outputs 0, mem[0x40] unchanged.
  - reset mid-stream → all outputs 0; lw AO=0x10 afterwards returns 0.
